// File: rtl/pcw_loader_pkg.sv
// Shared types and defaults for the PCW boot-ROM download controller.
package pcw_loader_pkg;

    typedef enum logic [2:0] {
        StResetIdle,
        StBoot,
        StWrite,
        StExec,
        StDone,
        StExt
    } loader_state_e;

    localparam int unsigned RomLenDefault   = 276;
    localparam logic [15:0] ExecAddrDefault = 16'h0000;

endpackage

// File: rtl/pcw_ce_tick.sv
// Modulo-CE_DIV pacing counter with synchronous restart; tick marks the last count.
module pcw_ce_tick #(
    parameter int unsigned CE_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(CE_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CE_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: restart wins, otherwise wrap at CE_DIV-1.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/pcw_boot_dl_ctrl.sv
// Boot-ROM copy sequencer into the PCW core download port, then host download pass-through.
module pcw_boot_dl_ctrl
    import pcw_loader_pkg::*;
#(
    parameter int unsigned ROM_LEN   = RomLenDefault,
    parameter int unsigned CE_DIV    = 16,
    parameter logic [15:0] EXEC_ADDR = ExecAddrDefault
) (
    input  logic        clk_sys,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    input  logic        dn_wait,
    output logic        execute_enable,
    output logic [15:0] execute_addr,
    input  logic        ext_go,
    input  logic        ext_wr,
    input  logic [15:0] ext_addr,
    input  logic [7:0]  ext_data,
    input  logic        boot_req,
    output logic        busy
);

    localparam logic [15:0] LastIdx = 16'(ROM_LEN - 1);

    loader_state_e state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic          go_q, go_d;
    logic          wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          exec_q, exec_d;
    logic          busy_q, busy_d;
    logic          restart;
    logic          tick;

    pcw_ce_tick #(
        .CE_DIV (CE_DIV)
    ) u_ce_tick (
        .clk_i     (clk_sys),
        .rst_i     (reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Next-state and download-port register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        go_d    = go_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        restart = 1'b0;
        case (state_q)
            StResetIdle: begin
                state_d = StBoot;
                go_d    = 1'b1;
                wr_d    = 1'b0;
                idx_d   = '0;
                addr_d  = '0;
                restart = 1'b1;
            end
            StBoot: begin
                addr_d = idx_q;
                // A full tick period has elapsed since rom_addr changed, so rom_data is valid.
                if (tick) begin
                    data_d  = rom_data;
                    wr_d    = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (tick && !dn_wait) begin
                    wr_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StExec;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        addr_d  = idx_q + 16'd1;
                        state_d = StBoot;
                    end
                end
            end
            StExec: begin
                go_d    = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                if (boot_req) begin
                    state_d = StBoot;
                    go_d    = 1'b1;
                    wr_d    = 1'b0;
                    idx_d   = '0;
                    addr_d  = '0;
                    // Realign pacing so the first ROM read gets a full period before its tick.
                    restart = 1'b1;
                end else if (ext_go) begin
                    state_d = StExt;
                    go_d    = ext_go;
                    wr_d    = ext_wr;
                    addr_d  = ext_addr;
                    data_d  = ext_data;
                end
            end
            StExt: begin
                go_d   = ext_go;
                wr_d   = ext_wr;
                addr_d = ext_addr;
                data_d = ext_data;
                if (!ext_go) begin
                    state_d = StDone;
                    go_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = StResetIdle;
            end
        endcase
    end

    // Status flags track the upcoming state so they line up with state_q.
    always_comb begin
        exec_d = (state_d == StExec);
        busy_d = (state_d != StDone);
    end

    // State and output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= StResetIdle;
            idx_q   <= '0;
            go_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            exec_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            go_q    <= go_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            exec_q  <= exec_d;
            busy_q  <= busy_d;
        end
    end

    assign rom_addr       = idx_q;
    assign dn_go          = go_q;
    assign dn_wr          = wr_q;
    assign dn_addr        = addr_q;
    assign dn_data        = data_q;
    assign execute_enable = exec_q;
    assign execute_addr   = EXEC_ADDR;
    assign busy           = busy_q;

endmodule
